// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler: default frame size, FSM encoding, counter widths.
package fft_pkg;

  localparam int FFT_POINTS_DEF = 256;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_FILL     = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_width(FFT_POINTS_DEF);

endpackage

// File: rtl/fft_rst_timer.sv
// Holds the FFT core in reset for RST_CYCLES clocks after sys_rst releases.
// o_expire marks the final hold cycle; o_rst_n rises on the edge that ends it.
module fft_rst_timer #(
  parameter int RST_CYCLES = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_expire,
  output logic o_rst_n
);

  localparam int W = $clog2(RST_CYCLES + 1);

  logic [W-1:0] r_cnt;
  logic         r_rst_n;

  assign o_expire = !r_rst_n && !i_rst && (r_cnt == W'(RST_CYCLES - 1));
  assign o_rst_n  = r_rst_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_rst_n <= 1'b0;
    end else if (!r_rst_n) begin
      if (o_expire) begin
        r_rst_n <= 1'b1;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Pulls FFT_POINTS samples per frame from the audio FIFO into the FFT sink, gapping frames by i_frame_gap.
// Counts completed frames and raises a sticky underrun when a frame starves for STALL_MAX cycles.
module fft_frame_scheduler
  import fft_pkg::*;
#(
  parameter int FFT_POINTS = FFT_POINTS_DEF,
  parameter int RST_CYCLES = 32,
  parameter int GAP_W      = 16,
  parameter int STALL_MAX  = 1024
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_frame_en,
  input  logic [GAP_W-1:0] i_frame_gap,
  input  logic             i_fifo_rd_empty,
  output logic             o_fifo_rdreq,
  input  logic             i_fft_ready,
  output logic             o_fft_rst_n,
  output logic             o_fft_sop,
  output logic             o_fft_eop,
  output logic             o_fft_valid,
  output logic             o_busy,
  output logic [15:0]      o_frame_cnt,
  output logic             o_underrun
);

  localparam int                 SC_W      = cnt_width(FFT_POINTS);
  localparam int                 STALL_W   = $clog2(STALL_MAX + 1);
  localparam logic [SC_W-1:0]    LAST_IDX  = SC_W'(FFT_POINTS - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  state_t             r_state;
  logic [SC_W-1:0]    r_sample_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_valid;
  logic               r_sop;
  logic               r_eop;
  logic               r_underrun;
  logic [15:0]        r_frame_cnt;

  logic w_fft_rst_n;
  logic w_rst_expire;
  logic w_rdreq;
  logic w_first;
  logic w_last;
  logic w_gap_done;
  logic w_stalled;

  fft_rst_timer #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst_timer (
    .i_clk    (i_sys_clk),
    .i_rst    (i_sys_rst),
    .o_expire (w_rst_expire),
    .o_rst_n  (w_fft_rst_n)
  );

  // Read request is combinational so a falling sink_ready stops reads in the same cycle.
  assign w_rdreq = (r_state == ST_FILL) && w_fft_rst_n && !i_sys_rst
                   && i_fft_ready && !i_fifo_rd_empty;
  assign w_first = w_rdreq && (r_sample_cnt == '0);
  assign w_last  = w_rdreq && (r_sample_cnt == LAST_IDX);

  // Widened compare tolerates frame_gap being lowered while a gap is already running.
  assign w_gap_done = ({1'b0, r_gap_cnt} + {{GAP_W{1'b0}}, 1'b1}) >= {1'b0, i_frame_gap};
  assign w_stalled  = (r_state == ST_FILL) && i_fifo_rd_empty;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= ST_RST_HOLD;
      r_sample_cnt <= '0;
      r_gap_cnt    <= '0;
    end else begin
      case (r_state)
        ST_RST_HOLD: begin
          if (w_rst_expire) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (i_frame_en) begin
            r_state      <= ST_FILL;
            r_sample_cnt <= '0;
          end
        end
        ST_FILL: begin
          if (w_last) begin
            r_sample_cnt <= '0;
            r_gap_cnt    <= '0;
            if (i_frame_gap != '0) r_state <= ST_GAP;
            else if (i_frame_en)   r_state <= ST_FILL;
            else                   r_state <= ST_IDLE;
          end else if (w_rdreq) begin
            r_sample_cnt <= r_sample_cnt + SC_W'(1);
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_sample_cnt <= '0;
            r_state      <= i_frame_en ? ST_FILL : ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= ST_RST_HOLD;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_frame_cnt <= '0;
      r_stall_cnt <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_valid <= w_rdreq;
      r_sop   <= w_first;
      r_eop   <= w_last;
      if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      // Stall count saturates; the frame keeps waiting for data rather than aborting.
      if (w_rdreq) begin
        r_stall_cnt <= '0;
      end else if (w_stalled) begin
        if (r_stall_cnt != STALL_LIM) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        if (r_stall_cnt == STALL_LIM - STALL_W'(1)) r_underrun <= 1'b1;
      end
    end
  end

  assign o_fifo_rdreq = w_rdreq;
  assign o_fft_rst_n  = w_fft_rst_n;
  assign o_fft_valid  = r_valid;
  assign o_fft_sop    = r_sop;
  assign o_fft_eop    = r_eop;
  assign o_busy       = (r_state == ST_FILL) || (r_state == ST_GAP);
  assign o_frame_cnt  = r_frame_cnt;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: scenario tasks plus a free-running stream monitor.
module tb_fft_frame_scheduler;

  localparam int N    = 256;
  localparam int RSTC = 32;
  localparam int GW   = 16;
  localparam int SMAX = 1024;

  logic          clk        = 1'b0;
  logic          sys_rst    = 1'b1;
  logic          frame_en   = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fft_ready  = 1'b0;
  logic [GW-1:0] frame_gap  = '0;
  logic          fifo_rdreq;
  logic          fft_rst_n;
  logic          fft_sop;
  logic          fft_eop;
  logic          fft_valid;
  logic          busy;
  logic          underrun;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit mon_en     = 1'b0;
  int m_idx      = 0;
  int m_frames   = 0;
  bit m_prev_rd  = 1'b0;

  int g_sop_t[$];
  int g_eop_t[$];
  int g_vc[$];

  always #10 clk = ~clk;

  fft_frame_scheduler #(
    .FFT_POINTS(N), .RST_CYCLES(RSTC), .GAP_W(GW), .STALL_MAX(SMAX)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (sys_rst),
    .i_frame_en      (frame_en),
    .i_frame_gap     (frame_gap),
    .i_fifo_rd_empty (fifo_empty),
    .o_fifo_rdreq    (fifo_rdreq),
    .i_fft_ready     (fft_ready),
    .o_fft_rst_n     (fft_rst_n),
    .o_fft_sop       (fft_sop),
    .o_fft_eop       (fft_eop),
    .o_fft_valid     (fft_valid),
    .o_busy          (busy),
    .o_frame_cnt     (frame_cnt),
    .o_underrun      (underrun)
  );

  // Stream model: valid follows the previous cycle's read, sop/eop tag sample index,
  // frame_cnt equals completed frames, and reads only happen when legal.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      n_checks++;
      if (fft_valid !== m_prev_rd) begin
        n_fail++; $display("FAIL valid_latency: valid=%b prev_rdreq=%b t=%0t", fft_valid, m_prev_rd, $time);
      end
      n_checks++;
      if (fifo_rdreq !== 1'b0 && (fifo_empty || !fft_ready || fft_rst_n !== 1'b1)) begin
        n_fail++; $display("FAIL rdreq_illegal: rdreq=%b empty=%b ready=%b rst_n=%b t=%0t", fifo_rdreq, fifo_empty, fft_ready, fft_rst_n, $time);
      end
      if (fft_valid === 1'b1) begin
        n_checks++;
        if (fft_sop !== 1'(m_idx == 0) || fft_eop !== 1'(m_idx == N - 1)) begin
          n_fail++; $display("FAIL sop_eop_tag: idx=%0d sop=%b eop=%b t=%0t", m_idx, fft_sop, fft_eop, $time);
        end
        if (m_idx == N - 1) begin
          m_idx = 0;
          m_frames++;
        end else begin
          m_idx++;
        end
      end else begin
        n_checks++;
        if (fft_sop !== 1'b0 || fft_eop !== 1'b0) begin
          n_fail++; $display("FAIL tag_without_valid: sop=%b eop=%b t=%0t", fft_sop, fft_eop, $time);
        end
      end
      n_checks++;
      if (frame_cnt !== 16'(m_frames)) begin
        n_fail++; $display("FAIL frame_cnt_track: got %0d expected %0d t=%0t", frame_cnt, m_frames, $time);
      end
      m_prev_rd = (fifo_rdreq === 1'b1);
      if (sys_rst) begin
        m_idx     = 0;
        m_frames  = 0;
        m_prev_rd = 1'b0;
      end
    end
  end

  task automatic wait_rst_release(output int cycles);
    cycles = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      cycles++;
      if (fft_rst_n === 1'b1) break;
    end
  endtask

  // mode 0: ready=1/never empty, mode 1: ready toggles every 3 cycles, mode 2: random ready/empty.
  task automatic run_frames(input int nf, input int mode, input int lim);
    int vc;
    vc = 0;
    g_sop_t.delete(); g_eop_t.delete(); g_vc.delete();
    frame_en = 1'b1;
    for (int t = 0; t < lim && g_eop_t.size() < nf; t++) begin
      @(negedge clk);
      case (mode)
        0:       begin fft_ready = 1'b1; fifo_empty = 1'b0; end
        1:       begin fft_ready = ((t / 3) % 2 == 0); fifo_empty = 1'b0; end
        default: begin fft_ready = ($urandom_range(0, 9) < 7); fifo_empty = ($urandom_range(0, 9) < 2); end
      endcase
      #1;
      if (fft_valid === 1'b1) begin
        if (fft_sop === 1'b1) begin
          g_sop_t.push_back(t);
          vc = 0;
          if (g_sop_t.size() == nf) frame_en = 1'b0;
        end
        vc++;
        if (fft_eop === 1'b1) begin
          g_eop_t.push_back(t);
          g_vc.push_back(vc);
        end
      end
    end
    frame_en = 1'b0;
    @(negedge clk);
    fft_ready = 1'b1; fifo_empty = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    int c;
    sys_rst = 1'b1; frame_en = 1'b0; fifo_empty = 1'b0; fft_ready = 1'b1; frame_gap = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({fft_rst_n, fft_valid, fft_sop, fft_eop, fifo_rdreq, busy, underrun} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: rst_n/valid/sop/eop/rdreq/busy/underrun=%b expected 0000000",
                         {fft_rst_n, fft_valid, fft_sop, fft_eop, fifo_rdreq, busy, underrun});
    end
    n_checks++;
    if (frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    mon_en = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    wait_rst_release(c);
    n_checks++;
    if (c != RSTC) begin
      n_fail++; $display("FAIL rst_hold_len: got %0d cycles expected %0d", c, RSTC);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || fifo_rdreq !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_hold: busy=%b rdreq=%b expected 0 0", busy, fifo_rdreq);
    end
  endtask

  task automatic test_contiguous();
    int fc0;
    fc0 = int'(frame_cnt);
    frame_gap = '0;
    run_frames(2, 0, 1200);
    n_checks++;
    if (g_eop_t.size() != 2 || g_sop_t.size() != 2) begin
      n_fail++; $display("FAIL contig_frames: got %0d eops expected 2", g_eop_t.size());
    end else begin
      n_checks++;
      if (g_vc[0] != N || g_eop_t[0] - g_sop_t[0] != N - 1) begin
        n_fail++; $display("FAIL contig_len: valids=%0d span=%0d expected %0d", g_vc[0], g_eop_t[0] - g_sop_t[0] + 1, N);
      end
      n_checks++;
      if (g_sop_t[1] != g_eop_t[0] + 1) begin
        n_fail++; $display("FAIL back_to_back: sop at %0d expected %0d", g_sop_t[1], g_eop_t[0] + 1);
      end
    end
    n_checks++;
    if (int'(frame_cnt) != fc0 + 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL contig_end: frame_cnt=%0d busy=%b expected %0d 0", frame_cnt, busy, fc0 + 2);
    end
  endtask

  task automatic test_ready_toggle();
    int fc0;
    fc0 = int'(frame_cnt);
    run_frames(2, 1, 3000);
    n_checks++;
    if (g_vc.size() != 2 || g_vc[0] != N || g_vc[1] != N) begin
      n_fail++; $display("FAIL toggle_len: frames=%0d valids0=%0d expected 2 %0d", g_vc.size(), (g_vc.size() > 0) ? g_vc[0] : -1, N);
    end
    n_checks++;
    if (int'(frame_cnt) != fc0 + 2) begin
      n_fail++; $display("FAIL toggle_frame_cnt: got %0d expected %0d", frame_cnt, fc0 + 2);
    end
  endtask

  task automatic test_random();
    int fc0, g;
    fc0 = int'(frame_cnt);
    g = $urandom_range(0, 3);
    frame_gap = GW'(g);
    run_frames(3, 2, 6000);
    n_checks++;
    if (g_vc.size() != 3) begin
      n_fail++; $display("FAIL random_frames: got %0d expected 3", g_vc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (g_vc[k] != N) begin
          n_fail++; $display("FAIL random_len: frame %0d valids=%0d expected %0d", k, g_vc[k], N);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (g_sop_t[k + 1] - g_eop_t[k] - 1 < g) begin
          n_fail++; $display("FAIL random_gap: idle=%0d expected >= %0d", g_sop_t[k + 1] - g_eop_t[k] - 1, g);
        end
      end
    end
    n_checks++;
    if (int'(frame_cnt) != fc0 + 3) begin
      n_fail++; $display("FAIL random_frame_cnt: got %0d expected %0d", frame_cnt, fc0 + 3);
    end
    frame_gap = '0;
  endtask

  task automatic test_gap();
    int g, fc0, vc, busy_cnt, stray;
    int sop_t[$];
    int eop_t[$];
    int vcs[$];
    g = $urandom_range(3, 12);
    fc0 = int'(frame_cnt);
    vc = 0; stray = 0;
    @(negedge clk);
    frame_gap = GW'(g); frame_en = 1'b1; fft_ready = 1'b1; fifo_empty = 1'b0;
    for (int t = 0; t < 2000 && eop_t.size() < 2; t++) begin
      @(negedge clk); #1;
      if (fft_valid === 1'b1) begin
        if (fft_sop === 1'b1) begin sop_t.push_back(t); vc = 0; end
        vc++;
        if (sop_t.size() == 2 && vc == 50) frame_en = 1'b0;
        if (fft_eop === 1'b1) begin eop_t.push_back(t); vcs.push_back(vc); end
      end
    end
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (busy !== 1'b1) break;
      busy_cnt++;
    end
    repeat (30) begin
      @(negedge clk); #1;
      if (fft_valid !== 1'b0 || busy !== 1'b0 || fifo_rdreq !== 1'b0) stray++;
    end
    n_checks++;
    if (eop_t.size() != 2 || sop_t.size() != 2) begin
      n_fail++; $display("FAIL gap_frames: got %0d eops expected 2", eop_t.size());
    end else begin
      n_checks++;
      if (sop_t[1] - eop_t[0] - 1 != g) begin
        n_fail++; $display("FAIL gap_spacing: idle=%0d expected %0d", sop_t[1] - eop_t[0] - 1, g);
      end
      n_checks++;
      if (vcs[1] != N) begin
        n_fail++; $display("FAIL gap_drop_en_len: valids=%0d expected %0d", vcs[1], N);
      end
    end
    n_checks++;
    if (busy_cnt != g) begin
      n_fail++; $display("FAIL gap_busy_len: got %0d expected %0d", busy_cnt, g);
    end
    n_checks++;
    if (stray != 0 || int'(frame_cnt) != fc0 + 2) begin
      n_fail++; $display("FAIL gap_idle: stray=%0d frame_cnt=%0d expected 0 %0d", stray, frame_cnt, fc0 + 2);
    end
    frame_gap = '0;
  endtask

  task automatic test_underrun();
    int fc0, rd, vc;
    bit saw_eop;
    fc0 = int'(frame_cnt);
    rd = 0; vc = 0; saw_eop = 1'b0;
    @(negedge clk);
    frame_gap = '0; frame_en = 1'b1; fft_ready = 1'b1; fifo_empty = 1'b0;
    for (int t = 0; t < 500 && rd < 100; t++) begin
      @(negedge clk); #1;
      if (fifo_rdreq === 1'b1) begin rd++; frame_en = 1'b0; end
      if (fft_valid === 1'b1) vc++;
    end
    n_checks++;
    if (underrun !== 1'b0 || rd != 100) begin
      n_fail++; $display("FAIL underrun_pre: underrun=%b reads=%0d expected 0 100", underrun, rd);
    end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      fifo_empty = 1'b1;
      #1;
      if (fft_valid === 1'b1) vc++;
      if (i == SMAX - 1) begin
        n_checks++;
        if (underrun !== 1'b0) begin
          n_fail++; $display("FAIL underrun_early: got %b at stall %0d expected 0", underrun, i);
        end
      end
      if (i == SMAX) begin
        n_checks++;
        if (underrun !== 1'b1) begin
          n_fail++; $display("FAIL underrun_set: got %b at stall %0d expected 1", underrun, i);
        end
      end
    end
    for (int t = 0; t < 600 && !saw_eop; t++) begin
      @(negedge clk);
      fifo_empty = 1'b0;
      #1;
      if (fft_valid === 1'b1) begin
        vc++;
        if (fft_eop === 1'b1) saw_eop = 1'b1;
      end
    end
    n_checks++;
    if (!saw_eop || vc != N) begin
      n_fail++; $display("FAIL underrun_resume: eop=%b valids=%0d expected 1 %0d", saw_eop, vc, N);
    end
    n_checks++;
    if (underrun !== 1'b1 || int'(frame_cnt) != fc0 + 1) begin
      n_fail++; $display("FAIL underrun_sticky: underrun=%b frame_cnt=%0d expected 1 %0d", underrun, frame_cnt, fc0 + 1);
    end
  endtask

  task automatic test_rst_midframe();
    int rd, c, vc;
    bit first_sop, got_first, saw_eop;
    rd = 0; vc = 0; got_first = 1'b0; first_sop = 1'b0; saw_eop = 1'b0;
    @(negedge clk);
    frame_gap = '0; frame_en = 1'b1; fft_ready = 1'b1; fifo_empty = 1'b0;
    for (int t = 0; t < 500 && rd < 128; t++) begin
      @(negedge clk); #1;
      if (fifo_rdreq === 1'b1) rd++;
    end
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({fft_rst_n, fft_valid, fft_sop, fft_eop, fifo_rdreq, busy, underrun} !== 7'b0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midframe_reset: rst_n/valid/sop/eop/rdreq/busy/underrun=%b frame_cnt=%0d expected all 0",
                         {fft_rst_n, fft_valid, fft_sop, fft_eop, fifo_rdreq, busy, underrun}, frame_cnt);
    end
    @(negedge clk);
    sys_rst = 1'b0;
    wait_rst_release(c);
    n_checks++;
    if (c != RSTC) begin
      n_fail++; $display("FAIL midframe_rst_hold: got %0d expected %0d", c, RSTC);
    end
    for (int t = 0; t < 800 && !saw_eop; t++) begin
      @(negedge clk); #1;
      if (fft_valid === 1'b1) begin
        if (!got_first) begin got_first = 1'b1; first_sop = fft_sop; frame_en = 1'b0; end
        vc++;
        if (fft_eop === 1'b1) saw_eop = 1'b1;
      end
    end
    n_checks++;
    if (first_sop !== 1'b1) begin
      n_fail++; $display("FAIL midframe_fresh_sop: got %b expected 1", first_sop);
    end
    n_checks++;
    if (!saw_eop || vc != N || frame_cnt !== 16'd1 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL midframe_fresh_frame: eop=%b valids=%0d frame_cnt=%0d underrun=%b expected 1 %0d 1 0",
                         saw_eop, vc, frame_cnt, underrun, N);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contiguous();
    test_ready_toggle();
    test_random();
    test_gap();
    test_underrun();
    test_rst_midframe();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
